// File: rtl/neopixel_chain.sv
`default_nettype none
// ============================================================================
// Module   : neopixel_chain
// Purpose  : WS2812/SK6812 single-wire driver streaming one frame from a
//            synchronous frame-buffer RAM, with byte prefetch and refresh mode.
// Revision : 1.0
// ============================================================================
module neopixel_chain #(
    parameter int NUM_LEDS      = 16,
    parameter int BYTES_PER_LED = 3,
    parameter int T_BIT         = 25,
    parameter int T0H           = 8,
    parameter int T1H           = 16,
    parameter int T_RESET       = 1600,
    parameter int ADDR_W        = 6
) (
    input  logic              clk_20M,
    input  logic              nrst,
    input  logic              start,
    input  logic              continuous,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              data
);

    localparam int NBYTES  = NUM_LEDS * BYTES_PER_LED;
    localparam int TIMER_W = $clog2(T_BIT);
    localparam int LATCH_W = (T_RESET > 1) ? $clog2(T_RESET) : 1;

    localparam logic [TIMER_W-1:0] C_BIT_LAST   = TIMER_W'(T_BIT - 1);
    localparam logic [TIMER_W-1:0] C_T0H        = TIMER_W'(T0H);
    localparam logic [TIMER_W-1:0] C_T1H        = TIMER_W'(T1H);
    localparam logic [LATCH_W-1:0] C_LATCH_LAST = LATCH_W'(T_RESET - 1);
    localparam logic [ADDR_W-1:0]  C_BYTE_LAST  = ADDR_W'(NBYTES - 1);

    if (!((T0H > 0) && (T0H < T1H) && (T1H < T_BIT))) begin : g_bad_timing
        $error("neopixel_chain: bit timing must satisfy 0 < T0H < T1H < T_BIT");
    end
    if (((1 << ADDR_W) < NBYTES) || (T_RESET < 1)) begin : g_bad_size
        $error("neopixel_chain: ADDR_W too small or T_RESET < 1");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        LATCH = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [TIMER_W-1:0] timer;
    logic [2:0]         bit_cnt;
    logic [ADDR_W-1:0]  byte_idx;
    logic [LATCH_W-1:0] latch_cnt;
    logic [7:0]         shift_reg;
    logic [7:0]         next_byte;
    logic               pref_pend;

    logic bit_end;
    logic last_byte;
    logic latch_end;
    logic prefetch;

    assign bit_end   = (timer == C_BIT_LAST);
    assign last_byte = (byte_idx == C_BYTE_LAST);
    assign latch_end = (latch_cnt == C_LATCH_LAST);
    // Read the following byte while the first bit of the current one goes out.
    assign prefetch  = (state == SHIFT) && (timer == '0) && (bit_cnt == 3'd7) && !last_byte;

    assign busy    = (state != IDLE);
    assign done    = (state == LATCH) && latch_end;
    assign rd_en   = (state == FETCH) || prefetch;
    assign rd_addr = prefetch ? (byte_idx + ADDR_W'(1)) : '0;

    always_ff @(posedge clk_20M or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: state_nxt = LOAD;
            LOAD:  state_nxt = SHIFT;
            SHIFT: begin
                if (bit_end && (bit_cnt == 3'd0) && last_byte) begin
                    state_nxt = LATCH;
                end
            end
            LATCH: begin
                if (latch_end) begin
                    state_nxt = continuous ? FETCH : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_20M or negedge nrst) begin
        if (!nrst) begin
            timer     <= '0;
            bit_cnt   <= '0;
            byte_idx  <= '0;
            latch_cnt <= '0;
            shift_reg <= '0;
            next_byte <= '0;
            pref_pend <= 1'b0;
            data      <= 1'b0;
        end else begin
            pref_pend <= prefetch;
            if (pref_pend) begin
                next_byte <= rd_data;
            end
            data <= 1'b0;
            case (state)
                LOAD: begin
                    shift_reg <= rd_data;
                    bit_cnt   <= 3'd7;
                    timer     <= '0;
                    byte_idx  <= '0;
                end
                SHIFT: begin
                    data <= (timer < (shift_reg[7] ? C_T1H : C_T0H));
                    if (bit_end) begin
                        timer <= '0;
                        if (bit_cnt != 3'd0) begin
                            shift_reg <= {shift_reg[6:0], 1'b0};
                            bit_cnt   <= bit_cnt - 3'd1;
                        end else if (!last_byte) begin
                            shift_reg <= next_byte;
                            bit_cnt   <= 3'd7;
                            byte_idx  <= byte_idx + ADDR_W'(1);
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                LATCH: begin
                    latch_cnt <= latch_end ? '0 : (latch_cnt + LATCH_W'(1));
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neopixel_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_neopixel_chain
// Purpose  : Scoreboard bench for neopixel_chain across three chain configurations.
// Revision : 1.0
// ============================================================================
module tb_neopixel_chain;

    localparam int T_BIT = 25;
    localparam int T0H   = 8;
    localparam int T1H   = 16;
    localparam int A_NB  = 48;
    localparam int B_NB  = 6;
    localparam int C_NB  = 12;
    localparam int A_TR  = 1600;
    localparam int B_TR  = 1600;
    localparam int C_TR  = 100;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #25 clk = ~clk;

    logic       a_start, a_cont, a_busy, a_done, a_rd_en, a_data;
    logic [5:0] a_rd_addr;
    logic [7:0] a_rd_data;
    logic       b_start, b_cont, b_busy, b_done, b_rd_en, b_data;
    logic [2:0] b_rd_addr;
    logic [7:0] b_rd_data;
    logic       c_start, c_cont, c_busy, c_done, c_rd_en, c_data;
    logic [3:0] c_rd_addr;
    logic [7:0] c_rd_data;

    logic [7:0] a_mem [64];
    logic [7:0] b_mem [8];
    logic [7:0] c_mem [16];

    neopixel_chain u_dut_a (
        .clk_20M(clk), .nrst(nrst), .start(a_start), .continuous(a_cont),
        .busy(a_busy), .done(a_done), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
        .rd_data(a_rd_data), .data(a_data)
    );

    neopixel_chain #(.NUM_LEDS(2), .BYTES_PER_LED(3), .ADDR_W(3)) u_dut_b (
        .clk_20M(clk), .nrst(nrst), .start(b_start), .continuous(b_cont),
        .busy(b_busy), .done(b_done), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
        .rd_data(b_rd_data), .data(b_data)
    );

    neopixel_chain #(.NUM_LEDS(3), .BYTES_PER_LED(4), .T_RESET(C_TR), .ADDR_W(4)) u_dut_c (
        .clk_20M(clk), .nrst(nrst), .start(c_start), .continuous(c_cont),
        .busy(c_busy), .done(c_done), .rd_en(c_rd_en), .rd_addr(c_rd_addr),
        .rd_data(c_rd_data), .data(c_data)
    );

    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
        if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
        if (c_rd_en) c_rd_data <= c_mem[c_rd_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor watches whichever chain is currently under test.
    int          sel = 0;
    logic        m_data, m_busy, m_done, m_rd_en;
    logic [31:0] m_addr;

    always_comb begin
        case (sel)
            0: begin
                m_data = a_data; m_busy = a_busy; m_done = a_done;
                m_rd_en = a_rd_en; m_addr = 32'(a_rd_addr);
            end
            1: begin
                m_data = b_data; m_busy = b_busy; m_done = b_done;
                m_rd_en = b_rd_en; m_addr = 32'(b_rd_addr);
            end
            default: begin
                m_data = c_data; m_busy = c_busy; m_done = c_done;
                m_rd_en = c_rd_en; m_addr = 32'(c_rd_addr);
            end
        endcase
    end

    function automatic int nbytes_of(input int s);
        return (s == 0) ? A_NB : (s == 1) ? B_NB : C_NB;
    endfunction

    function automatic int treset_of(input int s);
        return (s == 0) ? A_TR : (s == 1) ? B_TR : C_TR;
    endfunction

    function automatic logic [31:0] decode(input int w);
        return (w == T1H) ? 32'd1 : (w == T0H) ? 32'd0 : 32'd2;
    endfunction

    bit   exp_bits [$];
    int   exp_addr [$];
    bit   mon_en = 1'b0;
    bit   have_rise;
    logic prev_data = 1'b0, prev_busy = 1'b0, prev_done = 1'b0, prev_rd_en = 1'b0;
    int   hi_len, since_rise, low_run, busy_len, last_busy_len, last_w;
    int   done_cnt, n_reads, frame_done0;

    task automatic mon_clear();
        exp_bits.delete();
        exp_addr.delete();
        have_rise     = 1'b0;
        hi_len        = 0;
        since_rise    = 0;
        low_run       = 0;
        busy_len      = 0;
        last_busy_len = 0;
        last_w        = 0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            since_rise++;
            if (m_data) hi_len++;
            if (m_data && !prev_data) begin
                if (have_rise) check_eq("bit_period", since_rise, T_BIT);
                have_rise  = 1'b1;
                since_rise = 0;
            end
            if (!m_data && prev_data) begin
                last_w = hi_len;
                check_eq("bit_expected", 32'(exp_bits.size() > 0), 1);
                if (exp_bits.size() > 0) check_eq("bit_value", decode(hi_len), 32'(exp_bits.pop_front()));
                hi_len = 0;
            end
            low_run = m_data ? 0 : low_run + 1;
            if (m_busy) busy_len++;
            if (!m_busy && prev_busy) begin
                last_busy_len = busy_len;
                busy_len      = 0;
            end
            if (m_done) begin
                check_eq("done_width", prev_done, 0);
                check_eq("latch_low", low_run, T_BIT + treset_of(sel) - 1 - last_w);
                done_cnt++;
                have_rise = 1'b0;
            end
            if (m_rd_en) begin
                n_reads++;
                check_eq("rd_en_width", prev_rd_en, 0);
                check_eq("read_expected", 32'(exp_addr.size() > 0), 1);
                if (exp_addr.size() > 0) check_eq("rd_addr", m_addr, exp_addr.pop_front());
            end
        end
        prev_data  = m_data;
        prev_busy  = m_busy;
        prev_done  = m_done;
        prev_rd_en = m_rd_en;
    end

    task automatic push_frame(input int s);
        logic [7:0] v;
        for (int k = 0; k < nbytes_of(s); k++) begin
            case (s)
                0:       v = a_mem[k[5:0]];
                1:       v = b_mem[k[2:0]];
                default: v = c_mem[k[3:0]];
            endcase
            exp_addr.push_back(k);
            for (int i = 7; i >= 0; i--) exp_bits.push_back(v[i]);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        case (s)
            0:       a_start = v;
            1:       b_start = v;
            default: c_start = v;
        endcase
    endtask

    task automatic pulse_start(input int s);
        @(negedge clk);
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while ((done_cnt == d0) && (n < budget)) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("done_seen", 32'(done_cnt != d0), 1);
    endtask

    task automatic end_frame(input int nb, input int tr, input int n_done, input int n_busy);
        int highs = 0;
        @(negedge clk);
        #1;
        check_eq("busy_fall", m_busy, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_data) highs++;
        end
        #1;
        check_eq("idle_data", highs, 0);
        check_eq("busy_len", last_busy_len, n_busy * (2 + nb * 8 * T_BIT + tr));
        check_eq("done_count", done_cnt - frame_done0, n_done);
        check_eq("bits_left", exp_bits.size(), 0);
        check_eq("reads_left", exp_addr.size(), 0);
    endtask

    initial begin
        int n;
        a_start = 0; a_cont = 0;
        b_start = 0; b_cont = 0;
        c_start = 0; c_cont = 0;
        done_cnt = 0;
        n_reads  = 0;
        mon_clear();
        for (int k = 0; k < 64; k++) a_mem[k] = 8'h00;
        b_mem[0] = 8'h80; b_mem[1] = 8'h01; b_mem[2] = 8'hFF;
        b_mem[3] = 8'h00; b_mem[4] = 8'hAA; b_mem[5] = 8'h55;
        b_mem[6] = 8'h00; b_mem[7] = 8'h00;
        for (int k = 0; k < 16; k++) c_mem[k] = 8'(k * 37 + 5);

        repeat (3) @(negedge clk);
        check_eq("rst_data", a_data, 0);
        check_eq("rst_busy", a_busy, 0);
        check_eq("rst_done", a_done, 0);
        check_eq("rst_rd_en", a_rd_en, 0);
        check_eq("rst_rd_addr", a_rd_addr, 0);
        check_eq("rst_busy_b", b_busy, 0);
        check_eq("rst_busy_c", c_busy, 0);
        #5 nrst = 1'b1;
        mon_en = 1'b1;

        // Default chain, all-zero RAM: handshake latency then a full frame.
        sel = 0;
        frame_done0 = done_cnt;
        push_frame(0);
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check_eq("fetch_busy", a_busy, 1);
        check_eq("fetch_rd_en", a_rd_en, 1);
        check_eq("fetch_rd_addr", a_rd_addr, 0);
        @(negedge clk);
        check_eq("load_rd_en", a_rd_en, 0);
        @(negedge clk);
        check_eq("pre_rise_data", a_data, 0);
        @(negedge clk);
        check_eq("first_rise_data", a_data, 1);
        wait_done(12000);
        end_frame(A_NB, A_TR, 1, 1);

        // Two-LED chain with a mixed byte pattern.
        sel = 1;
        frame_done0 = done_cnt;
        push_frame(1);
        pulse_start(1);
        wait_done(4000);
        end_frame(B_NB, B_TR, 1, 1);

        // RGBW chain: read sequence and count.
        sel = 2;
        n_reads = 0;
        frame_done0 = done_cnt;
        push_frame(2);
        pulse_start(2);
        wait_done(4000);
        end_frame(C_NB, C_TR, 1, 1);
        check_eq("read_count", n_reads, C_NB);

        // Continuous refresh, dropped during the second frame.
        sel = 1;
        frame_done0 = done_cnt;
        push_frame(1);
        push_frame(1);
        b_cont = 1'b1;
        pulse_start(1);
        wait_done(4000);
        @(negedge clk);
        check_eq("refetch_busy", b_busy, 1);
        check_eq("refetch_rd_en", b_rd_en, 1);
        check_eq("refetch_rd_addr", b_rd_addr, 0);
        repeat (200) @(negedge clk);
        b_cont = 1'b0;
        wait_done(4000);
        end_frame(B_NB, B_TR, 2, 2);

        // start during SHIFT must not queue a second frame.
        frame_done0 = done_cnt;
        push_frame(1);
        pulse_start(1);
        repeat (300) @(negedge clk);
        pulse_start(1);
        wait_done(4000);
        end_frame(B_NB, B_TR, 1, 1);

        // start held high: one IDLE cycle between frames.
        frame_done0 = done_cnt;
        push_frame(1);
        push_frame(1);
        @(negedge clk);
        b_start = 1'b1;
        wait_done(4000);
        @(negedge clk);
        check_eq("held_idle_busy", b_busy, 0);
        @(negedge clk);
        check_eq("held_restart_busy", b_busy, 1);
        check_eq("held_restart_rd_en", b_rd_en, 1);
        b_start = 1'b0;
        wait_done(4000);
        end_frame(B_NB, B_TR, 2, 1);

        // Asynchronous reset in the middle of the fifth byte.
        frame_done0 = done_cnt;
        push_frame(1);
        pulse_start(1);
        n = 0;
        while (!(b_rd_en && (b_rd_addr == 3'd5)) && (n < 2000)) begin
            @(negedge clk);
            n++;
        end
        check_eq("byte5_prefetch", b_rd_en, 1);
        repeat (3 * T_BIT + 1) @(negedge clk);
        check_eq("pre_reset_data", b_data, 1);
        #5;
        mon_en = 1'b0;
        nrst   = 1'b0;
        #1;
        check_eq("async_rst_data", b_data, 0);
        check_eq("async_rst_busy", b_busy, 0);
        check_eq("async_rst_rd_en", b_rd_en, 0);
        check_eq("async_rst_rd_addr", b_rd_addr, 0);
        repeat (3) @(negedge clk);
        #5 nrst = 1'b1;
        mon_clear();
        mon_en = 1'b1;
        @(negedge clk);
        check_eq("post_rst_busy", b_busy, 0);
        check_eq("post_rst_data", b_data, 0);
        frame_done0 = done_cnt;
        push_frame(1);
        pulse_start(1);
        wait_done(4000);
        end_frame(B_NB, B_TR, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/neopixel_chain.md
Name: neopixel_chain

Overview:
- Parametrised WS2812/SK6812 serial driver; successor to the fixed 16-LED, hard-coded-pattern driver.
- Streams a frame of pixel bytes from an external synchronous frame-buffer RAM onto one single-wire output.
- Adds:
  - configurable chain length, bytes per LED (RGB or RGBW) and bit timing;
  - a start/busy/done handshake and a continuous-refresh mode;
  - byte prefetch, so consecutive bytes have no gap and no garbage first byte.
- Sits between the frame-buffer RAM and the LED data pin; the whole block runs in the 20 MHz domain.

Parameters:
- NUM_LEDS, 16, number of LEDs in the chain (1..1024).
- BYTES_PER_LED, 3, 3 for GRB, 4 for GRBW.
- T_BIT, 25, clocks per bit period (1.25 us at 20 MHz).
- T0H, 8, high clocks for a '0' bit.
- T1H, 16, high clocks for a '1' bit.
- T_RESET, 1600, low clocks of the latch/reset window (80 us).
- ADDR_W, 6, RAM address width; must satisfy 2^ADDR_W >= NUM_LEDS*BYTES_PER_LED.

Ports:
- clk_20M  in  1  20 MHz clock.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  request one frame; sampled only in IDLE.
- continuous  in  1  when 1, re-send the frame automatically after each latch.
- busy  out  1  high from the first FETCH cycle until the last LATCH cycle.
- done  out  1  single-cycle pulse on the final LATCH cycle of every frame.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  ADDR_W  RAM byte address; byte k = LED k/BYTES_PER_LED, colour k%BYTES_PER_LED.
- rd_data  in  8  RAM read data, valid exactly 1 cycle after rd_en.
- data  out  1  registered serial output to the LED chain.

Behaviour:
- Reset
  - nrst low forces all state immediately, mid-frame included: IDLE, data=0, busy=0, done=0, rd_en=0, rd_addr=0, all counters 0.
  - Behaviour resumes from IDLE on the first clock after release.
- Derived constants
  - NBYTES = NUM_LEDS*BYTES_PER_LED.
  - Legal timing requires 0 < T0H < T1H < T_BIT; illegal combinations are a simulation-time error.
- States: IDLE, FETCH, LOAD, SHIFT, LATCH.
- IDLE
  - data=0.
  - start=1 at an edge moves to FETCH, with busy=1, rd_en=1 and rd_addr=0 after that edge.
- FETCH: one cycle, then LOAD. rd_en drops.
- LOAD
  - One cycle; rd_data is captured into shift_reg.
  - bit_cnt=7, timer=0, byte_idx=0.
  - Next state is SHIFT.
- SHIFT
  - timer counts 0..T_BIT-1.
  - data is registered as (timer < (shift_reg[7] ? T1H : T0H)), so data lags timer by one cycle.
  - First rising edge of data is 3 clocks after the edge that sampled start.
  - Bits go out MSB first.
- Prefetch
  - In the cycle where timer==0 and bit_cnt==7 (first bit of a byte) and byte_idx < NBYTES-1: rd_en=1 and rd_addr=byte_idx+1.
  - The next cycle captures rd_data into next_byte.
  - rd_en is high for exactly one cycle per byte; NBYTES reads per frame in total.
- End of bit (timer==T_BIT-1)
  - timer returns to 0.
  - If bit_cnt>0: shift left and decrement bit_cnt.
  - If bit_cnt==0 and byte_idx<NBYTES-1: shift_reg<=next_byte, bit_cnt=7, byte_idx++.
  - If bit_cnt==0 and byte_idx==NBYTES-1: go to LATCH.
- Bit periods are contiguous, with no idle cycle between bytes. SHIFT lasts exactly NBYTES*8*T_BIT cycles.
- LATCH
  - data=0 for T_RESET cycles; done=1 on the last one.
  - Then: if continuous=1, go to FETCH (busy stays 1); else go to IDLE (busy=0).
- start is ignored whenever busy=1; no queuing.
- continuous is sampled only on the last LATCH cycle. Dropping it mid-frame completes the current frame.
- Counter widths:
  - timer: clog2(T_BIT) bits.
  - latch counter: clog2(T_RESET) bits.
  - byte_idx: ADDR_W bits.
  - No wrap-around is reachable within legal parameters.

Test Plan:
- Defaults, RAM all 0x00, start pulse:
  - 384 bits, each high 8 / low 17 cycles;
  - then 1600 low cycles, one done pulse;
  - busy high for 3+9600+1600-ish cycles, exact count checked against the model.
- NUM_LEDS=2, RAM = 0x80,0x01,0xFF,0x00,0xAA,0x55:
  - decoded bit stream equals those bytes MSB-first;
  - '1' highs are 16 cycles;
  - no gap at any byte boundary;
  - SHIFT length 1200 cycles.
- BYTES_PER_LED=4, NUM_LEDS=3: exactly 12 rd_en pulses with addresses 0..11 in order, each rd_en one cycle wide.
- continuous=1 for two frames, cleared during frame 2:
  - frame 2 starts with FETCH immediately after frame 1's done;
  - after frame 2's done, busy falls and data stays 0.
- start re-asserted during SHIFT, and start held high continuously with continuous=0:
  - the re-assertion during SHIFT is ignored;
  - with start held high, the next frame begins one cycle after return to IDLE.
- nrst pulled low mid-byte 5:
  - data, busy and rd_en go 0 asynchronously;
  - a later start transmits a full frame from address 0.
